// File: rtl/intr_flag_unit.sv
// Machine control flags, 16-way microcode jump condition and an edge-latched
// NIRQ interrupt controller. Define FLAG_IRQ_SYNC_EN to add 2-flop irq synchronisers.
module intr_flag_unit #(
  parameter int WIDTH = 32,
  parameter int NIRQ  = 8,
  parameter int VW    = $clog2(NIRQ)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             state_fetch,
  input  logic             destintctl,
  input  logic             destintmask,
  input  logic [WIDTH-1:0] ob,
  input  logic [WIDTH-1:0] r,
  input  logic [WIDTH:0]   alu,
  input  logic [48:0]      ir,
  input  logic             aeqm,
  input  logic             nopa,
  input  logic             vmaok,
  input  logic [NIRQ-1:0]  irq,
  input  logic             int_ack,
  output logic             jcond,
  output logic             lc_byte_mode,
  output logic             prog_unibus_reset,
  output logic             int_enable,
  output logic             sequence_break,
  output logic [NIRQ-1:0]  int_mask,
  output logic             int_pending,
  output logic [VW-1:0]    int_vector
);

  logic [NIRQ-1:0] irq_s;
  logic [NIRQ-1:0] irq_q;
  logic [NIRQ-1:0] pend;
  logic [NIRQ-1:0] vis;
  logic [NIRQ-1:0] clr;
  logic [3:0]      cs;
  logic            sint;
  logic            unused;

`ifdef FLAG_IRQ_SYNC_EN
  logic [NIRQ-1:0] sync1;
  logic [NIRQ-1:0] sync2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= irq;
      sync2 <= sync1;
    end
  end

  assign irq_s = sync2;
`else
  assign irq_s = irq;
`endif

  assign vis         = pend & int_mask;
  assign int_pending = |vis;
  assign sint        = int_pending & int_enable;

  always_comb begin
    int_vector = '0;
    for (int i = NIRQ - 1; i >= 0; i--) begin
      if (vis[i]) int_vector = VW'(i);
    end
  end

  always_comb begin
    clr = '0;
    if (int_ack && int_pending) clr[int_vector] = 1'b1;
  end

  // A new edge on the acknowledged line wins over the clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_q <= '0;
      pend  <= '0;
    end else begin
      irq_q <= irq_s;
      pend  <= (pend & ~clr) | (irq_s & ~irq_q);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lc_byte_mode      <= 1'b0;
      prog_unibus_reset <= 1'b0;
      int_enable        <= 1'b0;
      sequence_break    <= 1'b0;
      int_mask          <= '1;
    end else begin
      if (state_fetch && destintctl) begin
        lc_byte_mode      <= ob[WIDTH-3];
        prog_unibus_reset <= ob[WIDTH-4];
        int_enable        <= ob[WIDTH-5];
        sequence_break    <= ob[WIDTH-6];
      end
      if (state_fetch && destintmask) int_mask <= ob[NIRQ-1:0];
    end
  end

  assign cs = ir[5] ? ir[3:0] : 4'd0;

  always_comb begin
    jcond = 1'b0;
    case (cs)
      4'd0:  jcond = r[0];
      4'd1:  jcond = ~aeqm & alu[WIDTH];
      4'd2:  jcond = alu[WIDTH];
      4'd3:  jcond = aeqm;
      4'd4:  jcond = ~vmaok;
      4'd5:  jcond = ~vmaok | sint;
      4'd6:  jcond = ~vmaok | sint | sequence_break;
      4'd7:  jcond = 1'b1;
      4'd8:  jcond = r[WIDTH-1];
      4'd9:  jcond = (alu[WIDTH-1:0] == '0);
      4'd10: jcond = int_pending;
      4'd11: jcond = lc_byte_mode;
      4'd12: jcond = sequence_break;
      4'd13: jcond = int_enable;
      4'd14: jcond = ~aeqm;
      4'd15: jcond = 1'b0;
    endcase
  end

  assign unused = ^{ir[48:6], ir[4], nopa, ob, r};

endmodule

// File: tb/tb_intr_flag_unit.sv
// Directed and randomized bench for intr_flag_unit against a behavioural
// model of flags, pending latches, priority and jump conditions.
module tb_intr_flag_unit;

  localparam int WIDTH = 32;
  localparam int NIRQ  = 8;
  localparam int VW    = 3;
`ifdef FLAG_IRQ_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic             clk;
  logic             reset;
  logic             state_fetch;
  logic             destintctl;
  logic             destintmask;
  logic [WIDTH-1:0] ob;
  logic [WIDTH-1:0] r;
  logic [WIDTH:0]   alu;
  logic [48:0]      ir;
  logic             aeqm;
  logic             nopa;
  logic             vmaok;
  logic [NIRQ-1:0]  irq;
  logic             int_ack;
  logic             jcond;
  logic             lc_byte_mode;
  logic             prog_unibus_reset;
  logic             int_enable;
  logic             sequence_break;
  logic [NIRQ-1:0]  int_mask;
  logic             int_pending;
  logic [VW-1:0]    int_vector;

  int checks;
  int failures;

  bit       m_lc, m_pur, m_ie, m_sb;
  bit [7:0] m_mask;
  bit [7:0] m_pend;
  bit [7:0] m_prev;
  bit [7:0] line[$];

  intr_flag_unit #(.WIDTH(WIDTH), .NIRQ(NIRQ), .VW(VW)) dut (
    .clk(clk), .reset(reset), .state_fetch(state_fetch),
    .destintctl(destintctl), .destintmask(destintmask),
    .ob(ob), .r(r), .alu(alu), .ir(ir), .aeqm(aeqm), .nopa(nopa),
    .vmaok(vmaok), .irq(irq), .int_ack(int_ack), .jcond(jcond),
    .lc_byte_mode(lc_byte_mode), .prog_unibus_reset(prog_unibus_reset),
    .int_enable(int_enable), .sequence_break(sequence_break),
    .int_mask(int_mask), .int_pending(int_pending),
    .int_vector(int_vector)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int lowest(input bit [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return 0;
  endfunction

  function automatic bit exp_jcond();
    int  cs;
    bit  vis, sint;
    vis  = (m_pend & m_mask) != 0;
    sint = vis && m_ie;
    cs   = ir[5] ? int'(ir[3:0]) : 0;
    case (cs)
      0:  return r[0];
      1:  return !aeqm && alu[WIDTH];
      2:  return alu[WIDTH];
      3:  return aeqm;
      4:  return !vmaok;
      5:  return !vmaok || sint;
      6:  return !vmaok || sint || m_sb;
      7:  return 1'b1;
      8:  return r[WIDTH-1];
      9:  return alu[WIDTH-1:0] == 0;
      10: return vis;
      11: return m_lc;
      12: return m_sb;
      13: return m_ie;
      14: return !aeqm;
      default: return 1'b0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    bit [7:0] vis;
    vis = m_pend & m_mask;
    chk("lc_byte_mode", 64'(lc_byte_mode), 64'(m_lc));
    chk("prog_unibus_reset", 64'(prog_unibus_reset), 64'(m_pur));
    chk("int_enable", 64'(int_enable), 64'(m_ie));
    chk("sequence_break", 64'(sequence_break), 64'(m_sb));
    chk("int_mask", 64'(int_mask), 64'(m_mask));
    chk("int_pending", 64'(int_pending), 64'(vis != 0));
    chk("int_vector", 64'(int_vector), 64'(lowest(vis)));
    chk("jcond", 64'(jcond), 64'(exp_jcond()));
  endtask

  task automatic model_reset();
    m_lc = 0; m_pur = 0; m_ie = 0; m_sb = 0;
    m_mask = 8'hFF; m_pend = 0; m_prev = 0;
    line.delete();
    repeat (LAT) line.push_back(8'h00);
  endtask

  // Advance the model by one rising edge using the inputs now applied.
  task automatic model_edge();
    bit [7:0] s, vis, clr;
    line.push_back(irq);
    s   = line.pop_front();
    vis = m_pend & m_mask;
    clr = 0;
    if (int_ack && vis != 0) clr = 8'(1 << lowest(vis));
    if (state_fetch && destintctl) begin
      m_lc  = ob[WIDTH-3];
      m_pur = ob[WIDTH-4];
      m_ie  = ob[WIDTH-5];
      m_sb  = ob[WIDTH-6];
    end
    if (state_fetch && destintmask) m_mask = ob[7:0];
    m_pend = (m_pend & ~clr) | (s & ~m_prev);
    m_prev = s;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    chk("rst_mask", 64'(int_mask), 64'hFF);
    chk("rst_pending", 64'(int_pending), 64'h0);
    chk("rst_flags", 64'({lc_byte_mode, prog_unibus_reset,
                          int_enable, sequence_break}), 64'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    checks = 0; failures = 0;
    reset = 1'b1; state_fetch = 0; destintctl = 0; destintmask = 0;
    ob = '0; r = '0; alu = '0; ir = '0; aeqm = 0; nopa = 0;
    vmaok = 0; irq = '0; int_ack = 0;
    do_reset();

    // Request latency from a fresh rising edge
    irq = 8'h01;
    repeat (LAT) begin
      tick();
      chk("lat_early", 64'(int_pending), 64'h0);
    end
    tick();
    chk("lat_on_time", 64'(int_pending), 64'h1);
    irq = 0;
    do_reset();

    // Flag write
    state_fetch = 1; destintctl = 1; ob = 32'h2C00_0000;
    tick();
    chk("flag_write", 64'({lc_byte_mode, prog_unibus_reset,
                           int_enable, sequence_break}), 64'hB);
    destintctl = 0; ob = '0;
    tick();
    chk("flag_hold", 64'({lc_byte_mode, prog_unibus_reset,
                          int_enable, sequence_break}), 64'hB);
    state_fetch = 0;
    do_reset();

    // Priority and acknowledge
    irq = 8'h20; tick();
    irq = 8'h00; tick();
    irq = 8'h04; tick();
    irq = 8'h00;
    repeat (LAT + 1) tick();
    chk("prio_vec2", 64'(int_vector), 64'd2);
    int_ack = 1; tick(); int_ack = 0;
    chk("ack_vec5", 64'(int_vector), 64'd5);
    chk("ack_pend", 64'(int_pending), 64'h1);
    int_ack = 1; tick(); int_ack = 0;
    chk("ack_empty", 64'(int_pending), 64'h0);
    int_ack = 1; tick(); int_ack = 0;
    chk("ack_idle", 64'(int_pending), 64'h0);

    // Mask hides but does not block latching
    state_fetch = 1; destintmask = 1; ob = 32'hFB; tick();
    state_fetch = 0; destintmask = 0;
    irq = 8'h04; tick(); irq = 8'h00;
    repeat (LAT + 1) tick();
    chk("masked_pend", 64'(int_pending), 64'h0);
    state_fetch = 1; destintmask = 1; ob = 32'hFF; tick();
    state_fetch = 0; destintmask = 0;
    chk("unmask_pend", 64'(int_pending), 64'h1);
    chk("unmask_vec", 64'(int_vector), 64'd2);

    // Jump conditions with interrupt enable and irq[0] pending
    state_fetch = 1; destintctl = 1; ob = 32'h0800_0000; tick();
    state_fetch = 0; destintctl = 0;
    irq = 8'h01; tick(); irq = 8'h00;
    repeat (LAT + 1) tick();
    ir = 49'h25; vmaok = 1; #1;
    chk("jcond_sint", 64'(jcond), 64'h1);
    ir = '0; r = '0; #1;
    chk("jcond_cs0", 64'(jcond), 64'h0);
    r = 32'h1; #1;
    chk("jcond_r0", 64'(jcond), 64'h1);
    r = '0;

    // Asynchronous reset with state present
    do_reset();

    // Ack collides with a new edge on the same line
    irq = 8'h08; tick(); irq = 8'h00;
    repeat (LAT + 1) tick();
    chk("coll_pre", 64'(int_vector), 64'd3);
    irq = 8'h08;
    repeat (LAT) tick();
    int_ack = 1; tick(); int_ack = 0;
    chk("coll_pend", 64'(int_pending), 64'h1);
    chk("coll_vec", 64'(int_vector), 64'd3);
    irq = 8'h00;

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset();
      state_fetch = ($urandom_range(0, 3) == 0);
      destintctl  = 1'($urandom);
      destintmask = 1'($urandom);
      ob          = $urandom;
      r           = $urandom;
      alu         = ($urandom_range(0, 7) == 0) ? 33'($urandom_range(0, 1) << 32)
                                                : {1'($urandom), 32'($urandom)};
      ir          = 49'({$urandom, $urandom});
      aeqm        = 1'($urandom);
      nopa        = 1'($urandom);
      vmaok       = 1'($urandom);
      if ($urandom_range(0, 2) == 0) irq = 8'($urandom);
      int_ack     = ($urandom_range(0, 2) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
